// File: rtl/mist1032isa_uart_tx_arbiter_if.sv
// Bundle of the requester-side slot handshake and the UART transmitter link for the tx arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mist1032isa_uart_tx_arbiter_if;
   logic [3:0]  iREQ_VALID;
   logic [31:0] iREQ_DATA;
   logic [3:0]  oREQ_READY;
   logic [3:0]  iENABLE_MASK;
   logic        oTX_REQ;
   logic [7:0]  oTX_DATA;
   logic        iTX_BUSY;
   logic        oACTIVE;
   logic [1:0]  oACTIVE_ID;
   logic        oTIMEOUT;

   modport slave (
      input  iREQ_VALID, iREQ_DATA, iENABLE_MASK, iTX_BUSY,
      output oREQ_READY, oTX_REQ, oTX_DATA, oACTIVE, oACTIVE_ID, oTIMEOUT
   );

   modport master (
      output iREQ_VALID, iREQ_DATA, iENABLE_MASK, iTX_BUSY,
      input  oREQ_READY, oTX_REQ, oTX_DATA, oACTIVE, oACTIVE_ID, oTIMEOUT
   );
endinterface

// File: rtl/mist1032isa_uart_tx_arbiter.sv
// Four-slot round-robin arbiter feeding single bytes to a UART transmitter,
// with a bounded wait for the transmitter to acknowledge via its busy flag.
module mist1032isa_uart_tx_arbiter_slot (
   input  logic       iCLOCK,
   input  logic       iRESET,
   input  logic       iVALID,
   input  logic [7:0] iDATA,
   input  logic       iFREE,
   output logic       oFULL,
   output logic [7:0] oDATA
);
   // A slot is only freed while full, so accept and free never collide.
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         oFULL <= 1'b0;
         oDATA <= 8'h00;
      end else if (iVALID && !oFULL) begin
         oFULL <= 1'b1;
         oDATA <= iDATA;
      end else if (iFREE) begin
         oFULL <= 1'b0;
      end
   end
endmodule

module mist1032isa_uart_tx_arbiter #(
   parameter logic [7:0] WAIT_LIMIT = 8'd16
) (
   input logic                          iCLOCK,
   input logic                          iRESET,
   mist1032isa_uart_tx_arbiter_if.slave bus
);
   localparam int NUM_SLOTS = 4;

   typedef enum logic [1:0] {ARB, WAIT_BUSY, WAIT_DONE} state_t;

   state_t                          state_q, state_n;
   logic [NUM_SLOTS-1:0]            full;
   logic [NUM_SLOTS-1:0][7:0]       slot_data;
   logic [NUM_SLOTS-1:0]            slot_free;
   logic [NUM_SLOTS-1:0]            eligible;
   logic [1:0]                      ptr_q;
   logic [7:0]                      cnt_q, cnt_n;
   logic                            tx_req_q;
   logic [7:0]                      tx_data_q;
   logic [1:0]                      active_id_q;
   logic                            timeout_q;
   logic                            grant_valid;
   logic [1:0]                      grant_id;
   logic                            do_grant, do_free, do_timeout;

   for (genvar n = 0; n < NUM_SLOTS; n++) begin : g_slot
      mist1032isa_uart_tx_arbiter_slot u_slot (
         .iCLOCK (iCLOCK),
         .iRESET (iRESET),
         .iVALID (bus.iREQ_VALID[n]),
         .iDATA  (bus.iREQ_DATA[8*n +: 8]),
         .iFREE  (slot_free[n]),
         .oFULL  (full[n]),
         .oDATA  (slot_data[n])
      );
   end

   assign eligible  = full & bus.iENABLE_MASK;
   assign slot_free = do_free ? (4'b0001 << active_id_q) : 4'b0000;

   // Scan from the farthest offset down so the nearest eligible slot to ptr wins.
   always_comb begin
      logic [1:0] idx;
      grant_valid = 1'b0;
      grant_id    = ptr_q;
      idx         = ptr_q;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         idx = ptr_q + 2'(i);
         if (eligible[idx]) begin
            grant_valid = 1'b1;
            grant_id    = idx;
         end
      end
   end

   always_comb begin
      state_n    = state_q;
      cnt_n      = cnt_q;
      do_grant   = 1'b0;
      do_free    = 1'b0;
      do_timeout = 1'b0;
      case (state_q)
         ARB: begin
            if (!bus.iTX_BUSY && grant_valid) begin
               do_grant = 1'b1;
               cnt_n    = 8'd0;
               state_n  = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (bus.iTX_BUSY) begin
               state_n = WAIT_DONE;
            end else begin
               cnt_n = cnt_q + 8'd1;
               // Slot stays full and ptr is untouched, so ARB retries the same byte.
               if (cnt_q + 8'd1 == WAIT_LIMIT) begin
                  do_timeout = 1'b1;
                  state_n    = ARB;
               end
            end
         end
         WAIT_DONE: begin
            if (!bus.iTX_BUSY) begin
               do_free = 1'b1;
               state_n = ARB;
            end
         end
         default: state_n = ARB;
      endcase
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         state_q     <= ARB;
         cnt_q       <= 8'd0;
         ptr_q       <= 2'd0;
         tx_req_q    <= 1'b0;
         tx_data_q   <= 8'h00;
         active_id_q <= 2'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         tx_req_q  <= do_grant;
         timeout_q <= do_timeout;
         if (do_grant) begin
            tx_data_q   <= slot_data[grant_id];
            active_id_q <= grant_id;
         end
         if (do_free) ptr_q <= active_id_q + 2'd1;
      end
   end

   assign bus.oREQ_READY = ~full;
   assign bus.oTX_REQ    = tx_req_q;
   assign bus.oTX_DATA   = tx_data_q;
   assign bus.oACTIVE    = (state_q != ARB);
   assign bus.oACTIVE_ID = active_id_q;
   assign bus.oTIMEOUT   = timeout_q;
endmodule

// File: doc/mist1032isa_uart_tx_arbiter.md
MIST1032ISA_UART_TX_ARBITER -- requirements
Module: mist1032isa_uart_tx_arbiter

Interface
REQ-001 Parameter WAIT_LIMIT, default 8'd16: max cycles in WAIT_BUSY before timeout.
REQ-002 iCLOCK  in  1  sole clock; all state on rising edge.
REQ-003 iRESET  in  1  reset, asynchronous, active-high.
REQ-004 iREQ_VALID  in  4  requester n offers a byte.
REQ-005 iREQ_DATA  in  32  requester n byte on [8n+7:8n].
REQ-006 oREQ_READY  out  4  slot n buffer empty; transfer when valid&ready.
REQ-007 iENABLE_MASK  in  4  1 = slot n eligible for grant.
REQ-008 oTX_REQ  out  1  request to UART transmitter, registered.
REQ-009 oTX_DATA  out  8  byte to transmitter, registered.
REQ-010 iTX_BUSY  in  1  transmitter busy flag.
REQ-011 oACTIVE  out  1  high in WAIT_BUSY/WAIT_DONE.
REQ-012 oACTIVE_ID  out  2  slot currently granted; holds last grant otherwise.
REQ-013 oTIMEOUT  out  1  one-cycle pulse on busy-wait timeout.

Function
REQ-014 Four 1-byte slot buffers with full flags; oREQ_READY[n] = !full[n], combinational from flag only.
REQ-015 Accept: iREQ_VALID[n]&oREQ_READY[n] at edge -> buffer[n]<=byte, full[n]<=1; data is ignored otherwise.
REQ-016 States ARB, WAIT_BUSY, WAIT_DONE; reset state ARB.
REQ-017 Eligible[n] = full[n] & iENABLE_MASK[n].
REQ-018 ARB: if iTX_BUSY=0 and any eligible, winner = first eligible scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); next edge oTX_REQ<=1, oTX_DATA<=buffer[winner], oACTIVE_ID<=winner, wait counter<=0, state<=WAIT_BUSY.
REQ-019 ARB with iTX_BUSY=1 or no eligible: remain ARB, oTX_REQ<=0.
REQ-020 oTX_REQ high exactly one cycle per grant; deasserted on the edge leaving ARB's issue cycle.
REQ-021 WAIT_BUSY: iTX_BUSY=1 -> WAIT_DONE; else counter+1; counter==WAIT_LIMIT with busy still 0 -> oTIMEOUT pulse, state<=ARB, full[winner] kept, ptr unchanged (retry).
REQ-022 WAIT_DONE: iTX_BUSY=0 -> full[winner]<=0, ptr<=winner+1 mod 4, state<=ARB; else hold.
REQ-023 oTX_DATA holds value from grant until next grant; buffer[winner] not writable while full (ready low), so data stable during transmission.
REQ-024 Freeing slot n and accepting into slot m!=n on the same edge both take effect; slot n becomes ready the cycle after freeing.
REQ-025 Mask change mid-transmission does not abort current grant; affects next ARB only.
REQ-026 Latency: accept at edge k with idle transmitter and empty system -> ARB issue at edge k+1 -> oTX_REQ visible cycle after k+1.
REQ-027 Round-robin fairness: with all four slots continuously refilled, grant order 0,1,2,3,0...; no slot starved while eligible.

Reset
REQ-028 iRESET high asynchronously forces: state ARB, full=0000, ptr=0, counter=0, oTX_REQ=0, oTX_DATA=8'h00, oACTIVE_ID=0, oTIMEOUT=0; hence oREQ_READY=1111, oACTIVE=0.
REQ-029 Reset mid-transmission discards all buffered bytes; no oTX_REQ until iRESET deasserted and a new byte is accepted.

Verification
REQ-030 Single byte: slot 2 sends 8'hA5, transmitter model busy for 40 cycles -> one oTX_REQ pulse with oTX_DATA=A5, oACTIVE_ID=2, oREQ_READY[2] low until busy falls, then high next cycle.
REQ-031 All four slots loaded simultaneously (11,22,33,44), ptr=0 -> issue order 11,22,33,44, one oTX_REQ per byte, never while iTX_BUSY=1.
REQ-032 Mask: slots 0,1 full, iENABLE_MASK=4'b1110 -> only slot 1 sent; slot 0 stays full; set mask bit 0 -> slot 0 sent next.
REQ-033 Timeout: transmitter model never raises busy, WAIT_LIMIT=16 -> oTIMEOUT pulse after 16 WAIT_BUSY cycles, same byte reissued, slot stays full.
REQ-034 Refill race: slot 0 re-asserts valid continuously while slot 1 full -> grants alternate 0,1,0,1.
REQ-035 Reset during WAIT_DONE -> all outputs at REQ-028 values immediately (async), no further oTX_REQ after release.
